// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, config encodings, latched frame config and
// the baud divisor helper used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    localparam logic [1:0] DATA_5 = 2'b00;
    localparam logic [1:0] DATA_6 = 2'b01;
    localparam logic [1:0] DATA_7 = 2'b10;
    localparam logic [1:0] DATA_8 = 2'b11;

    localparam logic [1:0] STOP_1   = 2'b00;
    localparam logic [1:0] STOP_1P5 = 2'b01;
    localparam logic [1:0] STOP_2   = 2'b10;

    localparam logic [2:0] BAUD_4800   = 3'b000;
    localparam logic [2:0] BAUD_9600   = 3'b001;
    localparam logic [2:0] BAUD_19200  = 3'b010;
    localparam logic [2:0] BAUD_38400  = 3'b011;
    localparam logic [2:0] BAUD_57600  = 3'b100;
    localparam logic [2:0] BAUD_115200 = 3'b101;

    // Frame config captured at the start edge; 1.5 stop bits collapses to one checked bit.
    typedef struct packed {
        logic [2:0] baud;
        logic [1:0] data_bits;
        logic       two_stop;
        logic       parity_en;
        logic       parity_type;
    } rx_cfg_t;

    function automatic logic [15:0] baud_divisor(input logic [2:0] sel, input int freq,
                                                 input int rate);
        int baud;
        int div;
        case (sel)
            BAUD_4800:   baud = 4800;
            BAUD_9600:   baud = 9600;
            BAUD_19200:  baud = 19200;
            BAUD_38400:  baud = 38400;
            BAUD_57600:  baud = 57600;
            BAUD_115200: baud = 115200;
            default:     baud = 9600;
        endcase
        div = freq / (baud * rate);
        if (div < 1) div = 1;
        return div[15:0];
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversampling tick generator: one tick_o pulse every div_i clocks, re-aligned by clr_i.
module uart_baud_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            tick_o <= 1'b0;
        end else if (clr_i) begin
            cnt    <= '0;
            tick_o <= 1'b0;
        end else if (cnt >= div_i - 1'b1) begin
            cnt    <= '0;
            tick_o <= 1'b1;
        end else begin
            cnt    <= cnt + 1'b1;
            tick_o <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// UART receive path: synchronizer, start-edge detect, oversampled bit-centre sampling FSM,
// parity/framing checks and registered output word.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int SYSTEM_FREQUENCY = 10000000,
    parameter int SAMPLING_RATE    = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_i,
    input  logic       rx_en_i,
    input  logic [2:0] baud_sl_i,
    input  logic [1:0] data_bit_num,
    input  logic [1:0] stop_bit_num,
    input  logic       parity_en_i,
    input  logic       parity_type,
    output logic [7:0] data_o,
    output logic       rx_done_o,
    output logic       parity_err_o,
    output logic       frame_err_o,
    output logic       busy_o
);

    localparam int TW = $clog2(SAMPLING_RATE);
    localparam logic [TW-1:0] START_LAST = TW'(SAMPLING_RATE / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST   = TW'(SAMPLING_RATE - 1);

    rx_state_t     state;
    rx_cfg_t       cfg;
    logic          rx_s1, rx_s, rx_d;
    logic          fall, start_det, tick, sample_now;
    logic [TW-1:0] tick_cnt;
    logic [2:0]    bit_cnt, last_bit;
    logic [7:0]    shreg;
    logic          perr, ferr;
    logic [15:0]   div;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_s1 <= 1'b1;
            rx_s  <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= rx_i;
            rx_s  <= rx_s1;
            rx_d  <= rx_s;
        end
    end

    assign fall       = rx_d & ~rx_s;
    assign start_det  = (state == RX_IDLE) & fall & rx_en_i;
    assign div        = baud_divisor(cfg.baud, SYSTEM_FREQUENCY, SAMPLING_RATE);
    assign last_bit   = 3'd4 + {1'b0, cfg.data_bits};
    // Start bit is checked half a bit in; every later sample is a full bit further on.
    assign sample_now = tick & (tick_cnt == ((state == RX_START) ? START_LAST : BIT_LAST));

    uart_baud_gen #(
        .DIV_W(16)
    ) u_baud_gen (
        .clk    (clk),
        .reset_n(reset_n),
        .clr_i  (start_det),
        .div_i  (div),
        .tick_o (tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= RX_IDLE;
            cfg          <= '0;
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            perr         <= 1'b0;
            ferr         <= 1'b0;
            data_o       <= '0;
            rx_done_o    <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            rx_done_o <= 1'b0;
            if (!rx_en_i) begin
                state  <= RX_IDLE;
                busy_o <= 1'b0;
            end else begin
                if (state != RX_IDLE && tick)
                    tick_cnt <= sample_now ? '0 : tick_cnt + 1'b1;
                case (state)
                    RX_IDLE: begin
                        if (fall) begin
                            cfg      <= '{baud: baud_sl_i, data_bits: data_bit_num,
                                          two_stop: stop_bit_num[1], parity_en: parity_en_i,
                                          parity_type: parity_type};
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                            shreg    <= '0;
                            perr     <= 1'b0;
                            ferr     <= 1'b0;
                            state    <= RX_START;
                            busy_o   <= 1'b1;
                        end
                    end
                    RX_START: begin
                        if (sample_now) begin
                            if (!rx_s) begin
                                state <= RX_DATA;
                            end else begin
                                state  <= RX_IDLE;
                                busy_o <= 1'b0;
                            end
                        end
                    end
                    RX_DATA: begin
                        if (sample_now) begin
                            shreg[bit_cnt] <= rx_s;
                            if (bit_cnt == last_bit) begin
                                bit_cnt <= '0;
                                state   <= cfg.parity_en ? RX_PARITY : RX_STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    RX_PARITY: begin
                        if (sample_now) begin
                            perr  <= (^shreg ^ rx_s) != (cfg.parity_type ? 1'b0 : 1'b1);
                            state <= RX_STOP;
                        end
                    end
                    RX_STOP: begin
                        if (sample_now) begin
                            if (bit_cnt == {2'b00, cfg.two_stop}) begin
                                data_o       <= shreg;
                                parity_err_o <= cfg.parity_en & perr;
                                frame_err_o  <= ferr | ~rx_s;
                                rx_done_o    <= 1'b1;
                                state        <= RX_IDLE;
                                busy_o       <= 1'b0;
                            end else begin
                                ferr    <= ferr | ~rx_s;
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state  <= RX_IDLE;
                        busy_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: directed frame table, multi-cycle corner sequences and
// randomized frames checked against a frame-level reference model.
module tb_uart_receiver;

    localparam int FREQ = 10000000;
    localparam int SR   = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx_i = 1'b1;
    logic       rx_en_i = 1'b0;
    logic [2:0] baud_sl_i = 3'b101;
    logic [1:0] data_bit_num = 2'b11;
    logic [1:0] stop_bit_num = 2'b00;
    logic       parity_en_i = 1'b0;
    logic       parity_type = 1'b0;
    logic [7:0] data_o;
    logic       rx_done_o, parity_err_o, frame_err_o, busy_o;

    int n_cmp = 0;
    int n_bad = 0;
    logic [9:0] cap_q[$];

    always #50 clk = ~clk;

    uart_receiver #(
        .SYSTEM_FREQUENCY(FREQ),
        .SAMPLING_RATE   (SR)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx_i        (rx_i),
        .rx_en_i     (rx_en_i),
        .baud_sl_i   (baud_sl_i),
        .data_bit_num(data_bit_num),
        .stop_bit_num(stop_bit_num),
        .parity_en_i (parity_en_i),
        .parity_type (parity_type),
        .data_o      (data_o),
        .rx_done_o   (rx_done_o),
        .parity_err_o(parity_err_o),
        .frame_err_o (frame_err_o),
        .busy_o      (busy_o)
    );

    always @(negedge clk)
        if (reset_n && rx_done_o) cap_q.push_back({data_o, parity_err_o, frame_err_o});

    typedef struct {
        logic [2:0] baud;
        logic [1:0] dbits;
        logic [1:0] stop;
        logic       pen;
        logic       ptype;
        logic       pbit;
        logic       s2low;
        logic [7:0] data;
        logic [7:0] exp_data;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    vec_t vecs[6];

    function automatic int bit_clks(input logic [2:0] sel);
        int baud;
        case (sel)
            3'b000: baud = 4800;
            3'b010: baud = 19200;
            3'b011: baud = 38400;
            3'b100: baud = 57600;
            3'b101: baud = 115200;
            default: baud = 9600;
        endcase
        return (FREQ / (baud * SR)) * SR;
    endfunction

    // Frame-level expectation: word masked to its width, parity judged on total ones count.
    function automatic logic [9:0] model(input logic [7:0] d, input logic [1:0] dbits,
                                         input logic pen, input logic ptype, input logic pbit,
                                         input logic [1:0] stop, input logic s2low);
        int nbits = 5 + int'(dbits);
        int md = int'(d) % (1 << nbits);
        int ones = $countones(md) + int'(pbit);
        logic pe = pen && ((ones % 2) != (ptype ? 0 : 1));
        logic fe = stop[1] && s2low;
        return {md[7:0], pe, fe};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input logic pen,
                              input logic pbit, input int nstop, input logic s2low,
                              input int bclk, input logic scr);
        logic [2:0] sv_b = baud_sl_i;
        logic [1:0] sv_d = data_bit_num;
        logic [1:0] sv_s = stop_bit_num;
        logic       sv_p = parity_en_i;
        logic       sv_t = parity_type;
        rx_i = 1'b0;
        wait_clks(bclk);
        if (scr) begin
            baud_sl_i    = 3'($urandom_range(0, 7));
            data_bit_num = ~sv_d;
            stop_bit_num = ~sv_s;
            parity_en_i  = ~sv_p;
            parity_type  = ~sv_t;
        end
        for (int i = 0; i < nbits; i++) begin
            rx_i = d[i];
            wait_clks(bclk);
        end
        if (pen) begin
            rx_i = pbit;
            wait_clks(bclk);
        end
        for (int s = 0; s < nstop; s++) begin
            rx_i = !(s == 1 && s2low);
            wait_clks(bclk);
        end
        rx_i = 1'b1;
        baud_sl_i    = sv_b;
        data_bit_num = sv_d;
        stop_bit_num = sv_s;
        parity_en_i  = sv_p;
        parity_type  = sv_t;
    endtask

    task automatic expect_frame(input string nm, input logic [9:0] exp);
        logic [9:0] rec;
        int w = 0;
        while (cap_q.size() == 0 && w < 4000) begin
            @(negedge clk);
            w++;
        end
        if (cap_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no rx_done_o within bound, required data=%0h", nm, exp[9:2]);
        end else begin
            rec = cap_q.pop_front();
            chk({nm, " data_o"}, 32'(rec[9:2]), 32'(exp[9:2]));
            chk({nm, " parity_err_o"}, 32'(rec[1]), 32'(exp[1]));
            chk({nm, " frame_err_o"}, 32'(rec[0]), 32'(exp[0]));
        end
    endtask

    task automatic run_cfg_frame(input string nm, input logic [2:0] b, input logic [1:0] db,
                                 input logic [1:0] st, input logic pen, input logic pt,
                                 input logic pb, input logic s2l, input logic [7:0] d,
                                 input logic scr, input logic [9:0] exp);
        baud_sl_i    = b;
        data_bit_num = db;
        stop_bit_num = st;
        parity_en_i  = pen;
        parity_type  = pt;
        send_frame(d, 5 + int'(db), pen, pb, st[1] ? 2 : 1, s2l, bit_clks(b), scr);
        expect_frame(nm, exp);
        chk({nm, " extra pulses"}, 32'(cap_q.size()), 32'd0);
        chk({nm, " busy_o after frame"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        #8000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{3'b001, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h6A, 8'h6A, 1'b0, 1'b0};
        vecs[1] = '{3'b101, 2'b11, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h6B, 8'h6B, 1'b0, 1'b0};
        vecs[2] = '{3'b101, 2'b11, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h6B, 8'h6B, 1'b1, 1'b0};
        vecs[3] = '{3'b101, 2'b11, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 8'h6B, 8'h6B, 1'b0, 1'b1};
        vecs[4] = '{3'b100, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h1F, 1'b0, 1'b0};
        vecs[5] = '{3'b101, 2'b01, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 8'hC5, 8'h05, 1'b0, 1'b0};

        #1;
        chk("reset data_o", 32'(data_o), 32'd0);
        chk("reset rx_done_o", 32'(rx_done_o), 32'd0);
        chk("reset parity_err_o", 32'(parity_err_o), 32'd0);
        chk("reset frame_err_o", 32'(frame_err_o), 32'd0);
        chk("reset busy_o", 32'(busy_o), 32'd0);
        wait_clks(5);
        reset_n = 1'b1;
        rx_en_i = 1'b1;
        wait_clks(20);

        for (int i = 0; i < 6; i++) begin
            run_cfg_frame($sformatf("vec%0d", i), vecs[i].baud, vecs[i].dbits, vecs[i].stop,
                          vecs[i].pen, vecs[i].ptype, vecs[i].pbit, vecs[i].s2low,
                          vecs[i].data, 1'b0, {vecs[i].exp_data, vecs[i].exp_pe, vecs[i].exp_fe});
            wait_clks(20);
        end

        // Back-to-back frames, no idle between stop and next start.
        baud_sl_i = 3'b101; data_bit_num = 2'b11; stop_bit_num = 2'b00; parity_en_i = 1'b0;
        send_frame(8'hAB, 8, 1'b0, 1'b0, 1, 1'b0, 80, 1'b0);
        send_frame(8'h55, 8, 1'b0, 1'b0, 1, 1'b0, 80, 1'b0);
        expect_frame("b2b first", {8'hAB, 2'b00});
        expect_frame("b2b second", {8'h55, 2'b00});
        chk("b2b extra pulses", 32'(cap_q.size()), 32'd0);
        wait_clks(40);

        // Short low glitch: 4 ticks of 5 clks, shorter than the half-bit start check.
        rx_i = 1'b0;
        wait_clks(12);
        chk("glitch busy_o during", 32'(busy_o), 32'd1);
        wait_clks(8);
        rx_i = 1'b1;
        wait_clks(80);
        chk("glitch busy_o after", 32'(busy_o), 32'd0);
        chk("glitch no pulse", 32'(cap_q.size()), 32'd0);

        // Disable mid-frame: abort without pulse, outputs hold.
        rx_i = 1'b0;
        wait_clks(120);
        chk("rx_en busy_o before", 32'(busy_o), 32'd1);
        rx_en_i = 1'b0;
        wait_clks(2);
        chk("rx_en busy_o dropped", 32'(busy_o), 32'd0);
        rx_i = 1'b1;
        wait_clks(4);
        rx_en_i = 1'b1;
        wait_clks(200);
        chk("rx_en no pulse", 32'(cap_q.size()), 32'd0);
        chk("rx_en data_o held", 32'(data_o), 32'h55);

        run_cfg_frame("both errs", 3'b101, 2'b11, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 8'hC3, 1'b0,
                      {8'hC3, 1'b1, 1'b1});
        wait_clks(20);

        // Asynchronous reset in the middle of the data bits.
        rx_i = 1'b0;
        wait_clks(80);
        rx_i = 1'b0; wait_clks(80);
        rx_i = 1'b1; wait_clks(80);
        rx_i = 1'b1; wait_clks(40);
        chk("midreset busy_o before", 32'(busy_o), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("midreset data_o", 32'(data_o), 32'd0);
        chk("midreset parity_err_o", 32'(parity_err_o), 32'd0);
        chk("midreset frame_err_o", 32'(frame_err_o), 32'd0);
        chk("midreset busy_o", 32'(busy_o), 32'd0);
        rx_i = 1'b1;
        wait_clks(4);
        reset_n = 1'b1;
        wait_clks(160);
        chk("midreset no pulse", 32'(cap_q.size()), 32'd0);
        run_cfg_frame("after reset", 3'b101, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3E, 1'b0,
                      {8'h3E, 2'b00});
        wait_clks(20);

        for (int i = 0; i < 16; i++) begin
            logic [2:0] b = ($urandom_range(0, 3) == 0) ? 3'b100 : 3'b101;
            logic [1:0] db = 2'($urandom_range(0, 3));
            logic [1:0] st = 2'($urandom_range(0, 3));
            logic pen = 1'($urandom_range(0, 1));
            logic pt = 1'($urandom_range(0, 1));
            logic pb = 1'($urandom_range(0, 1));
            logic s2l = st[1] && ($urandom_range(0, 3) == 0);
            logic [7:0] d = 8'($urandom_range(0, 255));
            logic scr = ($urandom_range(0, 2) == 0);
            run_cfg_frame($sformatf("rand%0d", i), b, db, st, pen, pt, pb, s2l, d, scr,
                          model(d, db, pen, pt, pb, st, s2l));
            wait_clks($urandom_range(1, 40));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
